syndrome_round_source: RTL and testbench
========================================

SYNDROME_ROUND_SOURCE -- requirements
Module: syndrome_round_source

Interface
REQ-001 SHALL have parameter PU_COUNT, default 18, number of syndrome bits per round (1..1024).
REQ-002 SHALL have parameter LANES, default 8, bits per fill beat (1..32).
REQ-003 SHALL have parameter UPDATE_DELAY, default 10, cycles from start pulse to first fill beat (1..255).
REQ-004 SHALL have parameter FLYING_DELAY, default 4, depth of message-flying hold-off (2..32).
REQ-005 SHALL have parameter LFSR_SEED, default 32'hACE1_2468, nonzero reset state of a 32-bit Galois LFSR with taps 0x8020_0003.
REQ-006 SHALL have ports: clk input 1, rising-edge clock; reset input 1, synchronous active-low reset (asserted when 0).
REQ-007 SHALL have ports: start input 1, round request pulse (stage entered measurement loading); mode input 1, 0 = random, 1 = external; density input 2, random density select.
REQ-008 SHALL have ports: load_data input LANES, external beat; load_valid input 1; load_ready output 1.
REQ-009 SHALL have ports: is_error_syndromes output PU_COUNT, committed round; syndromes_valid output 1, one-cycle commit pulse; round_count output 16, committed rounds; busy output 1; overrun output 1, sticky.
REQ-010 SHALL have ports: flying_in input 1, raw message-flying OR from grid and interconnect; has_message_flying output 1, delayed/held flag.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, FILL, COMMIT; BEATS = ceil(PU_COUNT/LANES).
REQ-012 IDLE: on start=1 (or pending=1) SHALL go to WAIT, load delay counter with UPDATE_DELAY-1, clear pending; mode and density SHALL be sampled here and held for the round.
REQ-013 WAIT: counter decrements each cycle; at 0 SHALL go to FILL with beat index 0; first beat no earlier than UPDATE_DELAY cycles after start.
REQ-014 FILL random mode: one beat per cycle, LFSR steps once per beat; load_ready SHALL be 0.
REQ-015 Random beat word SHALL be, for new LFSR state S: density 0 -> S; 1 -> S & rotr(S,7); 2 -> S & rotr(S,7) & rotr(S,13); 3 -> all zeros; low LANES bits used.
REQ-016 FILL external mode: load_ready SHALL be 1; beat accepted only when load_valid & load_ready; no accept -> state held, no timeout.
REQ-017 Beat k SHALL be written to assembly bits [k*LANES +: LANES]; bits at or above PU_COUNT in last beat SHALL be discarded.
REQ-018 After beat BEATS-1 SHALL go to COMMIT; COMMIT lasts exactly one cycle: assembly copied to is_error_syndromes, syndromes_valid=1, round_count += 1 (wraps 0xFFFF -> 0), then IDLE.
REQ-019 is_error_syndromes SHALL change only in COMMIT; stable otherwise.
REQ-020 busy SHALL be 1 in WAIT, FILL, COMMIT; 0 in IDLE.
REQ-021 start while busy SHALL set a one-deep pending flag; start while pending already set SHALL set overrun; request dropped.
REQ-022 start in the COMMIT cycle SHALL set pending (next round starts from IDLE next cycle).
REQ-023 LFSR SHALL advance only on random-mode beats; external rounds SHALL not disturb it.
REQ-024 Flying shift register SR[FLYING_DELAY-1:0]: SR[0] <= flying_in, SR[i] <= SR[i-1]; has_message_flying SHALL be OR of SR (registered input plus hold-off, no combinational path from flying_in).

Reset
REQ-025 With reset=0 at a rising edge: state IDLE, pending 0, overrun 0, counter 0, SR 0, LFSR = LFSR_SEED, assembly 0, is_error_syndromes 0, syndromes_valid 0, round_count 0, load_ready 0, busy 0, has_message_flying 0.
REQ-026 Reset mid-round SHALL abandon the round with no commit and no round_count change; outputs take REQ-025 values the cycle after the reset edge.
REQ-027 start sampled during reset SHALL be ignored.

Verification
REQ-028 Defaults, random, density 3, start at cycle 0 -> syndromes_valid pulse at cycle 10+3+1=14 with is_error_syndromes=0, round_count=1, busy low at cycle 15.
REQ-029 External, PU_COUNT 18, LANES 8, beats 0xA5, 0x3C, 0xFF with load_valid gaps -> is_error_syndromes=18'h33CA5, upper 6 bits of 0xFF discarded, LFSR unchanged.
REQ-030 Random density 0, two rounds -> round 1 equals reference-model LFSR words from LFSR_SEED; round 2 continues the sequence, not reseeded.
REQ-031 Start at cycles 0, 3, 5 -> pending set at 3, overrun=1 at 6, exactly two commits, round_count=2.
REQ-032 reset=0 during FILL beat 1 -> no syndromes_valid, round_count 0, LFSR=LFSR_SEED; next start completes normally.
REQ-033 flying_in single-cycle pulse at cycle 5, FLYING_DELAY 4 -> has_message_flying 1 for cycles 6..9, 0 at 10.

Source files
------------

// File: rtl/syndrome_round_source.sv
// -----------------------------------------------------------------------------
// syndrome_round_source
//
// Produces one round of PU_COUNT error-syndrome bits each time a round is
// requested. A round waits UPDATE_DELAY cycles after the request, then fills an
// assembly register LANES bits per beat, either from an internal 32-bit Galois
// LFSR (mode 0) or from an external beat stream (mode 1). It then commits the
// assembled word in a single COMMIT cycle. A separate shift register turns the
// raw message-flying OR into a registered, held-off flag.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-low
//   start               round request pulse
//   mode                0 = random fill, 1 = external fill (sampled at round start)
//   density             random density select (sampled at round start)
//   load_data           external fill beat
//   load_valid          external beat offered
//   load_ready          external beat can be taken (FILL state, external mode)
//   is_error_syndromes  committed round, stable outside COMMIT
//   syndromes_valid     high for the single COMMIT cycle
//   round_count         number of committed rounds, wraps at 16 bits
//   busy                round in progress (WAIT, FILL, COMMIT)
//   overrun             sticky: a request was dropped
//   flying_in           raw message-flying OR from grid and interconnect
//   has_message_flying  OR of the flying hold-off shift register
//   fsm_state           current FSM state, for observation
//
// Handshake: an external beat transfers on a rising edge where
// load_valid & load_ready are both 1. load_ready does not depend on
// load_valid. The source may hold load_valid low for any number of cycles;
// the round waits without a timeout.
// -----------------------------------------------------------------------------
module syndrome_round_source #(
   parameter int          PU_COUNT     = 18,
   parameter int          LANES        = 8,
   parameter int          UPDATE_DELAY = 10,
   parameter int          FLYING_DELAY = 4,
   parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                mode,
   input  logic [1:0]          density,
   input  logic [LANES-1:0]    load_data,
   input  logic                load_valid,
   output logic                load_ready,
   output logic [PU_COUNT-1:0] is_error_syndromes,
   output logic                syndromes_valid,
   output logic [15:0]         round_count,
   output logic                busy,
   output logic                overrun,
   input  logic                flying_in,
   output logic                has_message_flying,
   output logic [1:0]          fsm_state
);

   localparam int BEATS  = (PU_COUNT + LANES - 1) / LANES;
   localparam int ASM_W  = BEATS * LANES;
   localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BIDX_W-1:0] LAST_BEAT  = BIDX_W'(BEATS - 1);
   localparam logic [31:0]       TAPS       = 32'h8020_0003;
   localparam logic [7:0]        DELAY_LOAD = 8'(UPDATE_DELAY - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_FILL   = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   state_t                  state, next_state;
   logic                    pending;
   logic [7:0]              delay_cnt;
   logic [BIDX_W-1:0]       beat_idx;
   logic [31:0]             lfsr;
   logic [ASM_W-1:0]        assembly;
   logic                    mode_q;
   logic [1:0]              density_q;
   logic [FLYING_DELAY-1:0] flying_sr;

   logic                    beat_fire;
   logic [31:0]             lfsr_next;
   logic [31:0]             rnd_full;
   logic [LANES-1:0]        beat_word;
   logic [ASM_W-1:0]        asm_next;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state      = state;
      load_ready      = 1'b0;
      syndromes_valid = 1'b0;
      busy            = 1'b1;
      beat_fire       = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start || pending) next_state = ST_WAIT;
         end
         ST_WAIT: begin
            if (delay_cnt == 8'd0) next_state = ST_FILL;
         end
         ST_FILL: begin
            load_ready = mode_q;
            // Random beats are produced every cycle; external beats need the handshake.
            beat_fire  = mode_q ? (load_valid & load_ready) : 1'b1;
            if (beat_fire && (beat_idx == LAST_BEAT)) next_state = ST_COMMIT;
         end
         ST_COMMIT: begin
            syndromes_valid = 1'b1;
            next_state      = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign fsm_state = state;

   // ------------------------------------------------------- beat datapath
   assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);

   always_comb begin
      rnd_full = 32'h0;
      case (density_q)
         2'd0: rnd_full = lfsr_next;
         2'd1: rnd_full = lfsr_next & {lfsr_next[6:0], lfsr_next[31:7]};
         2'd2: rnd_full = lfsr_next & {lfsr_next[6:0], lfsr_next[31:7]}
                                    & {lfsr_next[12:0], lfsr_next[31:13]};
         default: rnd_full = 32'h0;
      endcase
   end

   assign beat_word = mode_q ? load_data : LANES'(rnd_full);

   always_comb begin
      asm_next = assembly;
      asm_next[int'(beat_idx) * LANES +: LANES] = beat_word;
   end

   // Round bookkeeping. The committed word and round_count are loaded on the
   // edge that enters COMMIT, so they are already valid during the COMMIT
   // cycle when syndromes_valid is high.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pending            <= 1'b0;
         overrun            <= 1'b0;
         delay_cnt          <= 8'd0;
         beat_idx           <= '0;
         lfsr               <= LFSR_SEED;
         assembly           <= '0;
         mode_q             <= 1'b0;
         density_q          <= 2'd0;
         is_error_syndromes <= '0;
         round_count        <= 16'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start || pending) begin
                  delay_cnt <= DELAY_LOAD;
                  mode_q    <= mode;
                  density_q <= density;
                  // A fresh start arriving while a pending request is
                  // consumed becomes the next pending request.
                  pending   <= pending & start;
               end
            end
            ST_WAIT: begin
               if (delay_cnt != 8'd0) delay_cnt <= delay_cnt - 8'd1;
               else                   beat_idx  <= '0;
            end
            ST_FILL: begin
               if (beat_fire) begin
                  assembly <= asm_next;
                  beat_idx <= beat_idx + BIDX_W'(1);
                  if (!mode_q) lfsr <= lfsr_next;
                  if (beat_idx == LAST_BEAT) begin
                     // Bits at or above PU_COUNT in the last beat are dropped here.
                     is_error_syndromes <= PU_COUNT'(asm_next);
                     round_count        <= round_count + 16'd1;
                  end
               end
            end
            default: ;
         endcase
         // One request can queue behind the running round; a second is dropped.
         if (busy && start) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
         end
      end
   end

   // ----------------------------------------------- message-flying hold-off
   always_ff @(posedge clk) begin
      if (!reset) flying_sr <= '0;
      else        flying_sr <= {flying_sr[FLYING_DELAY-2:0], flying_in};
   end

   assign has_message_flying = |flying_sr;

endmodule

// File: tb/tb_syndrome_round_source.sv
// -----------------------------------------------------------------------------
// tb_syndrome_round_source
//
// Directed bench for syndrome_round_source at default parameters
// (PU_COUNT 18, LANES 8, UPDATE_DELAY 10, FLYING_DELAY 4). Random-mode rounds
// are predicted by a reference LFSR model kept in the bench. "rel N" in the
// comments means N rising edges after the edge that sampled start.
// -----------------------------------------------------------------------------
module tb_syndrome_round_source;

   localparam int          PU   = 18;
   localparam int          LN   = 8;
   localparam int          FD   = 4;
   localparam logic [31:0] SEED = 32'hACE1_2468;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   logic          clk;
   logic          reset;
   logic          start;
   logic          mode;
   logic [1:0]    density;
   logic [LN-1:0] load_data;
   logic          load_valid;
   logic          load_ready;
   logic [PU-1:0] is_error_syndromes;
   logic          syndromes_valid;
   logic [15:0]   round_count;
   logic          busy;
   logic          overrun;
   logic          flying_in;
   logic          has_message_flying;
   logic [1:0]    fsm_state;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_valid = 0;
   int          exp_rc  = 0;
   int          v0;
   int          i;
   logic [31:0] lfsr_m;

   syndrome_round_source #(
      .PU_COUNT(PU), .LANES(LN), .UPDATE_DELAY(10), .FLYING_DELAY(FD), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .density(density),
      .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
      .is_error_syndromes(is_error_syndromes), .syndromes_valid(syndromes_valid),
      .round_count(round_count), .busy(busy), .overrun(overrun),
      .flying_in(flying_in), .has_message_flying(has_message_flying),
      .fsm_state(fsm_state)
   );

   // ---------------------------------------------------- clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) if (reset && syndromes_valid === 1'b1) n_valid++;

   // ------------------------------------------------------- reference model
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
   endfunction

   function automatic logic [LN-1:0] rnd_beat(input logic [31:0] s, input logic [1:0] d);
      logic [31:0] r7, r13, w;
      r7  = (s >> 7)  | (s << 25);
      r13 = (s >> 13) | (s << 19);
      case (d)
         2'd0:    w = s;
         2'd1:    w = s & r7;
         2'd2:    w = s & r7 & r13;
         default: w = 32'h0;
      endcase
      return w[LN-1:0];
   endfunction

   // Predicts one random round of three beats and advances the model LFSR.
   task automatic model_round(input logic [1:0] d, output logic [PU-1:0] exp_word);
      logic [23:0] a;
      a = '0;
      for (int k = 0; k < 3; k++) begin
         lfsr_m = lfsr_step(lfsr_m);
         a[k*LN +: LN] = rnd_beat(lfsr_m, d);
      end
      exp_word = a[PU-1:0];
   endtask

   // ---------------------------------------------------------- driver tasks
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input logic [1:0] d, input logic m);
      mode    = m;
      density = d;
      start   = 1'b1;
      step(1);
      start   = 1'b0;
   endtask

   task automatic wait_commit(input string tag, input int budget);
      int j;
      j = 0;
      while (syndromes_valid !== 1'b1 && j < budget) begin
         step(1);
         j++;
      end
      check({tag, "_commit_seen"}, {31'h0, syndromes_valid}, 32'h1);
   endtask

   task automatic run_random(input logic [1:0] d, input string tag);
      logic [PU-1:0] e;
      pulse_start(d, 1'b0);
      model_round(d, e);
      wait_commit(tag, 40);
      exp_rc++;
      check({tag, "_data"}, {14'h0, is_error_syndromes}, {14'h0, e});
      check({tag, "_count"}, {16'h0, round_count}, 32'(exp_rc));
      step(1);
   endtask

   // -------------------------------------------------------------- sequence
   initial begin
      reset = 1'b0; start = 1'b1; mode = 1'b0; density = 2'd0;
      load_data = '0; load_valid = 1'b0; flying_in = 1'b0;
      lfsr_m = SEED;

      // start held high throughout reset must not launch a round
      step(3);
      reset = 1'b1; start = 1'b0;
      check("rst_busy",       {31'h0, busy}, 32'h0);
      check("rst_valid",      {31'h0, syndromes_valid}, 32'h0);
      check("rst_count",      {16'h0, round_count}, 32'h0);
      check("rst_syndromes",  {14'h0, is_error_syndromes}, 32'h0);
      check("rst_load_ready", {31'h0, load_ready}, 32'h0);
      check("rst_overrun",    {31'h0, overrun}, 32'h0);
      check("rst_flying",     {31'h0, has_message_flying}, 32'h0);
      check("rst_state",      {30'h0, fsm_state}, 32'h0);
      step(20);
      check("rst_start_ignored_busy",  {31'h0, busy}, 32'h0);
      check("rst_start_ignored_valid", 32'(n_valid), 32'h0);

      // Random density 3: commit exactly at rel 14, idle at rel 15
      pulse_start(2'd3, 1'b0);
      check("d3_busy_rel1", {31'h0, busy}, 32'h1);
      step(12);
      check("d3_no_early_valid", {31'h0, syndromes_valid}, 32'h0);
      step(1);
      check("d3_valid_rel14", {31'h0, syndromes_valid}, 32'h1);
      check("d3_data", {14'h0, is_error_syndromes}, 32'h0);
      check("d3_count", {16'h0, round_count}, 32'h1);
      begin
         logic [PU-1:0] dummy;
         model_round(2'd3, dummy);
      end
      exp_rc = 1;
      step(1);
      check("d3_idle_rel15", {31'h0, busy}, 32'h0);
      check("d3_valid_drop", {31'h0, syndromes_valid}, 32'h0);

      // External round with load_valid gaps: A5, 3C, FF -> 18'h33CA5
      pulse_start(2'd0, 1'b1);
      i = 0;
      while (load_ready !== 1'b1 && i < 40) begin
         step(1);
         i++;
      end
      check("ext_ready_seen", {31'h0, load_ready}, 32'h1);
      check("ext_ready_rel11", 32'(i), 32'd10);
      step(2);
      check("ext_stall_ready", {31'h0, load_ready}, 32'h1);
      check("ext_stall_busy", {31'h0, busy}, 32'h1);
      load_data = 8'hA5; load_valid = 1'b1; step(1);
      load_valid = 1'b0; step(1);
      load_data = 8'h3C; load_valid = 1'b1; step(1);
      load_valid = 1'b0; step(2);
      check("ext_no_early_valid", {31'h0, syndromes_valid}, 32'h0);
      load_data = 8'hFF; load_valid = 1'b1; step(1);
      load_valid = 1'b0;
      check("ext_valid", {31'h0, syndromes_valid}, 32'h1);
      check("ext_data", {14'h0, is_error_syndromes}, 32'h0003_3CA5);
      check("ext_count", {16'h0, round_count}, 32'h2);
      check("ext_commit_not_ready", {31'h0, load_ready}, 32'h0);
      exp_rc = 2;
      step(1);
      check("ext_hold_data", {14'h0, is_error_syndromes}, 32'h0003_3CA5);

      // Random rounds continue the LFSR sequence untouched by the external round
      run_random(2'd0, "d0_r1");
      run_random(2'd0, "d0_r2");
      run_random(2'd1, "d1");
      run_random(2'd2, "d2");

      // Starts at rel 0, 3, 5: one queued, one dropped
      mode = 1'b0; density = 2'd3;
      v0 = n_valid;
      start = 1'b1; step(1); start = 1'b0;
      step(2);
      start = 1'b1; step(1); start = 1'b0;
      check("ovr_clear_rel4", {31'h0, overrun}, 32'h0);
      step(1);
      check("ovr_clear_rel5", {31'h0, overrun}, 32'h0);
      start = 1'b1; step(1); start = 1'b0;
      check("ovr_set_rel6", {31'h0, overrun}, 32'h1);
      step(40);
      check("ovr_two_commits", 32'(n_valid - v0), 32'd2);
      exp_rc += 2;
      check("ovr_count", {16'h0, round_count}, 32'(exp_rc));
      check("ovr_sticky", {31'h0, overrun}, 32'h1);
      check("ovr_idle", {31'h0, busy}, 32'h0);
      begin
         logic [PU-1:0] dummy;
         model_round(2'd3, dummy);
         model_round(2'd3, dummy);
      end

      // Reset during FILL beat 1 abandons the round
      pulse_start(2'd0, 1'b0);
      step(11);
      check("mid_in_fill", {30'h0, fsm_state}, 32'h2);
      reset = 1'b0;
      step(1);
      check("mid_busy", {31'h0, busy}, 32'h0);
      check("mid_valid", {31'h0, syndromes_valid}, 32'h0);
      check("mid_count", {16'h0, round_count}, 32'h0);
      check("mid_overrun", {31'h0, overrun}, 32'h0);
      check("mid_syndromes", {14'h0, is_error_syndromes}, 32'h0);
      reset = 1'b1;
      v0 = n_valid;
      lfsr_m = SEED;
      exp_rc = 0;
      step(15);
      check("mid_no_commit", 32'(n_valid - v0), 32'h0);
      run_random(2'd0, "post_reset");

      // Flying pulse in rel 5 -> flag high rel 6..9, low rel 10
      step(5);
      flying_in = 1'b1;
      check("fly_no_comb_path", {31'h0, has_message_flying}, 32'h0);
      step(1);
      flying_in = 1'b0;
      for (int k = 6; k <= 9; k++) begin
         check($sformatf("fly_rel%0d", k), {31'h0, has_message_flying}, 32'h1);
         step(1);
      end
      check("fly_rel10", {31'h0, has_message_flying}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
